// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and the data cache (DC).
// Data wins by default; a streak counter hands fetch the slot after MAX_D_STREAK contested data grants.
module mem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_ack,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int SW = $clog2(MAX_D_STREAK + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_I = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

   logic [1:0]    state;
   logic [SW-1:0] d_streak;
   mem_cmd_t      cmd;
   logic          i_ok;
   logic          streak_full;
   logic          gnt_d;
   logic          gnt_i;

   // Fetch is masked while flushing and in its own ack cycle (req still high for the finished word).
   // dc_req stays eligible in its ack cycle so the cache can stream back-to-back accesses.
   always_comb begin
      i_ok        = if_req && !if_flush && !if_ack;
      streak_full = (d_streak == SW'(MAX_D_STREAK));
      gnt_d       = (state == IDLE) && dc_req && !(i_ok && streak_full);
      gnt_i       = (state == IDLE) && i_ok && !gnt_d;
   end

   assign busy      = (state != IDLE);
   assign mem_req   = busy;
   assign mem_we    = cmd.we;
   assign mem_addr  = cmd.addr;
   assign mem_wdata = cmd.wdata;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         d_streak <= '0;
         cmd      <= '0;
         if_ack   <= 1'b0;
         dc_ack   <= 1'b0;
         if_rdata <= '0;
         dc_rdata <= '0;
      end else begin
         if_ack <= 1'b0;
         dc_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_d) begin
                  state <= GNT_D;
                  cmd   <= '{we: dc_we, addr: dc_addr, wdata: dc_wdata};
                  // Streak counts raw if_req so a masked fetch still sees the limit approach
                  if (!if_req)
                     d_streak <= '0;
                  else if (!streak_full)
                     d_streak <= d_streak + SW'(1);
               end else if (gnt_i) begin
                  state    <= GNT_I;
                  cmd      <= '{we: 1'b0, addr: if_addr, wdata: '0};
                  d_streak <= '0;
               end
            end
            GNT_I: begin
               if (mem_ready) begin
                  state <= IDLE;
                  if (!if_flush) begin
                     if_ack   <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else if (if_flush) begin
                  state <= DRAIN;
               end
            end
            GNT_D: begin
               if (mem_ready) begin
                  state  <= IDLE;
                  dc_ack <= 1'b1;
                  if (!cmd.we)
                     dc_rdata <= mem_rdata;
               end
            end
            default: begin
               if (mem_ready)
                  state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bench drives the memory side by hand, one task per scenario.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        if_req, if_flush, dc_req, dc_we, mem_ready;
   logic [15:0] if_addr, dc_addr, dc_wdata, mem_rdata;
   logic        if_ack, dc_ack, mem_req, mem_we, busy;
   logic [15:0] if_rdata, dc_rdata, mem_addr, mem_wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_D_STREAK(4)) dut (
      .clk(clk), .n_rst(n_rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_ack(if_ack), .if_rdata(if_rdata),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_ack(dc_ack), .dc_rdata(dc_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      n_rst = 1'b0;
      if_req = 0; if_flush = 0; dc_req = 0; dc_we = 0; mem_ready = 0;
      if_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
      #12;
      checks++;
      if ({if_ack, if_rdata, dc_ack, dc_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
         errors++; $display("FAIL reset_outputs: got mem_req=%b busy=%b mem_addr=%h, want all zero", mem_req, busy, mem_addr);
      end
      n_rst = 1'b1;
      tick;
      dc_req = 1; dc_addr = 16'h0080;
      tick;
      checks++;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_pre_gnt_d: mem_req=%b want 1", mem_req); end
      #2 n_rst = 1'b0;
      #1;
      checks++;
      if ({mem_req, busy, if_ack, dc_ack} !== 4'b0) begin
         errors++; $display("FAIL reset_async: {mem_req,busy,if_ack,dc_ack}=%b want 0000", {mem_req, busy, if_ack, dc_ack});
      end
      dc_req = 0;
      #2 n_rst = 1'b1;
      tick;
      checks++;
      if (busy !== 1'b0 || dut.d_streak !== '0) begin
         errors++; $display("FAIL reset_release: busy=%b d_streak=%0d want 0 0", busy, dut.d_streak);
      end
   endtask

   task automatic test_single_read;
      dc_req = 1; dc_we = 0; dc_addr = 16'h0040;
      tick;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || mem_we !== 1'b0) begin
         errors++; $display("FAIL read_grant: mem_req=%b addr=%h we=%b want 1 0040 0", mem_req, mem_addr, mem_we);
      end
      tick;
      checks++;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL read_req_c2: mem_req=%b want 1", mem_req); end
      tick;
      checks++;
      if (mem_req !== 1'b1 || dc_ack !== 1'b0) begin
         errors++; $display("FAIL read_req_c3: mem_req=%b dc_ack=%b want 1 0", mem_req, dc_ack);
      end
      mem_ready = 1; mem_rdata = 16'hBEEF;
      tick;
      mem_ready = 0;
      checks++;
      if (dc_ack !== 1'b1 || dc_rdata !== 16'hBEEF || mem_req !== 1'b0) begin
         errors++; $display("FAIL read_ack: dc_ack=%b dc_rdata=%h mem_req=%b want 1 beef 0", dc_ack, dc_rdata, mem_req);
      end
      dc_req = 0;
      tick;
      checks++;
      if (dc_ack !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL read_after: dc_ack=%b busy=%b want 0 0", dc_ack, busy);
      end
   endtask

   task automatic test_starvation;
      string      pat;
      logic [7:0] kind;
      pat = "DDDDIDDDDI";
      if_req = 1; if_addr = 16'h0300;
      dc_req = 1; dc_we = 0; dc_addr = 16'h0050;
      for (int g = 0; g < 10; g++) begin
         int wait_n;
         wait_n = 0;
         while (mem_req !== 1'b1 && wait_n < 8) begin tick; wait_n++; end
         checks++;
         if (mem_req !== 1'b1) begin errors++; $display("FAIL starve_timeout: grant %0d never issued", g); end
         kind = (mem_addr == 16'h0300) ? "I" : "D";
         checks++;
         if (kind != pat[g]) begin
            errors++; $display("FAIL starve_order: grant %0d is %s want %s", g, kind, pat[g]);
         end
         mem_ready = 1; mem_rdata = 16'hA000 + 16'(g);
         tick;
         mem_ready = 0;
         checks++;
         if (pat[g] == "I") begin
            if (if_ack !== 1'b1 || dc_ack !== 1'b0 || if_rdata !== 16'hA000 + 16'(g)) begin
               errors++; $display("FAIL starve_if_ack: grant %0d if_ack=%b dc_ack=%b if_rdata=%h want 1 0 %h", g, if_ack, dc_ack, if_rdata, 16'hA000 + 16'(g));
            end
         end else begin
            if (dc_ack !== 1'b1 || if_ack !== 1'b0 || dc_rdata !== 16'hA000 + 16'(g)) begin
               errors++; $display("FAIL starve_dc_ack: grant %0d dc_ack=%b if_ack=%b dc_rdata=%h want 1 0 %h", g, dc_ack, if_ack, dc_rdata, 16'hA000 + 16'(g));
            end
         end
         if (g == 9) begin if_req = 0; dc_req = 0; end
      end
      tick;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL starve_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_flush_mid;
      if_req = 1; if_addr = 16'h0100;
      tick;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0100 || mem_we !== 1'b0 || mem_wdata !== 16'h0000) begin
         errors++; $display("FAIL flush_grant: req=%b addr=%h we=%b wdata=%h want 1 0100 0 0000", mem_req, mem_addr, mem_we, mem_wdata);
      end
      if_flush = 1; if_req = 0;
      tick;
      if_flush = 0;
      checks++;
      if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== 16'h0100 || if_ack !== 1'b0) begin
         errors++; $display("FAIL flush_drain: req=%b busy=%b addr=%h if_ack=%b want 1 1 0100 0", mem_req, busy, mem_addr, if_ack);
      end
      mem_ready = 1; mem_rdata = 16'hDEAD;
      tick;
      mem_ready = 0;
      checks++;
      if (if_ack !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 16'hA009) begin
         errors++; $display("FAIL flush_no_ack: if_ack=%b req=%b if_rdata=%h want 0 0 a009", if_ack, mem_req, if_rdata);
      end
      if_req = 1; if_addr = 16'h0200;
      tick;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin
         errors++; $display("FAIL flush_next_grant: req=%b addr=%h want 1 0200", mem_req, mem_addr);
      end
      mem_ready = 1; mem_rdata = 16'h2222;
      tick;
      mem_ready = 0;
      checks++;
      if (if_ack !== 1'b1 || if_rdata !== 16'h2222) begin
         errors++; $display("FAIL flush_next_ack: if_ack=%b if_rdata=%h want 1 2222", if_ack, if_rdata);
      end
      if_req = 0;
      tick;
   endtask

   task automatic test_edge_flush;
      if_req = 1; if_addr = 16'h0400;
      tick;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0400) begin
         errors++; $display("FAIL edge_grant: req=%b addr=%h want 1 0400", mem_req, mem_addr);
      end
      mem_ready = 1; mem_rdata = 16'h5555; if_flush = 1; if_req = 0;
      tick;
      mem_ready = 0; if_flush = 0;
      checks++;
      if (if_ack !== 1'b0 || if_rdata !== 16'h2222 || busy !== 1'b0) begin
         errors++; $display("FAIL edge_flush: if_ack=%b if_rdata=%h busy=%b want 0 2222 0", if_ack, if_rdata, busy);
      end
      tick;
      checks++;
      if (if_ack !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL edge_after: if_ack=%b busy=%b want 0 0", if_ack, busy);
      end
   endtask

   task automatic test_flush_idle;
      if_req = 1; if_addr = 16'h0600; if_flush = 1;
      tick;
      if_flush = 0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_block: busy=%b want 0", busy); end
      tick;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0600) begin
         errors++; $display("FAIL idle_flush_late: req=%b addr=%h want 1 0600", mem_req, mem_addr);
      end
      mem_ready = 1; mem_rdata = 16'h6666;
      tick;
      mem_ready = 0;
      checks++;
      if (if_ack !== 1'b1 || if_rdata !== 16'h6666) begin
         errors++; $display("FAIL idle_flush_ack: if_ack=%b if_rdata=%h want 1 6666", if_ack, if_rdata);
      end
      // if_req still high through the ack cycle: must not be re-granted
      tick;
      checks++;
      if (busy !== 1'b0 || if_ack !== 1'b0) begin
         errors++; $display("FAIL ack_mask: busy=%b if_ack=%b want 0 0", busy, if_ack);
      end
      if_req = 0;
      tick;
   endtask

   task automatic test_write;
      dc_req = 1; dc_we = 1; dc_addr = 16'h0010; dc_wdata = 16'h1234;
      tick;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h1234) begin
         errors++; $display("FAIL write_grant: req=%b we=%b addr=%h wdata=%h want 1 1 0010 1234", mem_req, mem_we, mem_addr, mem_wdata);
      end
      tick;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h1234) begin
         errors++; $display("FAIL write_hold: req=%b we=%b addr=%h wdata=%h want 1 1 0010 1234", mem_req, mem_we, mem_addr, mem_wdata);
      end
      mem_ready = 1; mem_rdata = 16'h9999;
      tick;
      mem_ready = 0;
      checks++;
      if (dc_ack !== 1'b1 || dc_rdata !== 16'hA008 || mem_req !== 1'b0) begin
         errors++; $display("FAIL write_ack: dc_ack=%b dc_rdata=%h req=%b want 1 a008 0", dc_ack, dc_rdata, mem_req);
      end
      dc_req = 0; dc_we = 0;
      tick;
      checks++;
      if (dc_ack !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL write_after: dc_ack=%b busy=%b want 0 0", dc_ack, busy);
      end
   endtask

   initial begin
      test_reset;
      test_single_read;
      test_starvation;
      test_flush_mid;
      test_edge_flush;
      test_flush_idle;
      test_write;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
